// File: rtl/qreg_pkg.sv
// Shared definitions for the qreg sequencer: qreg mode encodings and sequencer states.
package qreg_pkg;

    localparam logic [1:0] MODE_LOAD  = 2'b00;
    localparam logic [1:0] MODE_SHIFT = 2'b01;
    localparam logic [1:0] MODE_HOLD  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/qreg_seq_if.sv
// Control bundle between the datapath, the sequencer and qreg's mode/serial inputs.
interface qreg_seq_if #(
    parameter int unsigned CNT_W = 3
);
    logic             start;
    logic [CNT_W-1:0] nshift;
    logic             rotate;
    logic             ser_in;
    logic             q0_fb;
    logic             pause;
    logic             C1;
    logic             C0;
    logic             si;
    logic             busy;
    logic             done;

    modport master (
        output start, nshift, rotate, ser_in, q0_fb, pause,
        input  C1, C0, si, busy, done
    );

    modport slave (
        input  start, nshift, rotate, ser_in, q0_fb, pause,
        output C1, C0, si, busy, done
    );
endinterface

// File: rtl/qreg_seq.sv
// Load/shift/hold sequencer for qreg: parallel-load D, shift right nshift times, then hold and flag done.
module qreg_seq
    import qreg_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic        clock,
    input  logic        reset,
    qreg_seq_if.slave   bus
);

    if (2 ** CNT_W <= WIDTH) begin : g_cnt_too_narrow
        $error("qreg_seq: CNT_W cannot represent a shift count of WIDTH");
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             rot_q;
    logic [1:0]       mode;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            rot_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        cnt   <= bus.nshift;
                        rot_q <= bus.rotate;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state <= (cnt != '0) ? ST_SHIFT : ST_DONE;
                end
                ST_SHIFT: begin
                    // A paused cycle drives Hold, so it must not consume a shift.
                    if (!bus.pause) begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            state <= ST_DONE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mode = MODE_HOLD;
        case (state)
            ST_LOAD:  mode = MODE_LOAD;
            ST_SHIFT: mode = bus.pause ? MODE_HOLD : MODE_SHIFT;
            default:  mode = MODE_HOLD;
        endcase
    end

    assign bus.C1   = mode[1];
    assign bus.C0   = mode[0];
    assign bus.si   = rot_q ? bus.q0_fb : bus.ser_in;
    assign bus.busy = (state != ST_IDLE);
    assign bus.done = (state == ST_DONE);

endmodule

// File: tb/tb_qreg_seq.sv
// Bench for qreg_seq driving a behavioural 4-bit qreg, checked every cycle against a sequence-level model.
module tb_qreg_seq;

    logic       clock;
    logic       reset;
    logic [3:0] d;
    logic [3:0] q = 4'h0;

    int errors = 0;
    int checks = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int shift_cnt = 0;
    bit chk_en = 1'b0;

    // Sequence-level model: phase 0 idle, 1 load, 2 shifting, 3 done.
    int         m_ph = 0;
    int         m_left = 0;
    bit         m_rot = 1'b0;
    logic [3:0] m_q = 4'h0;
    logic [1:0] em;

    qreg_seq_if #(.CNT_W(3)) bus ();

    qreg_seq #(.WIDTH(4), .CNT_W(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural qreg: 00 load, 01 shift right with si into Q3, otherwise hold.
    always @(posedge clock) begin
        case ({bus.C1, bus.C0})
            2'b00:   q <= d;
            2'b01:   q <= {bus.si, q[3:1]};
            default: q <= q;
        endcase
    end

    assign bus.q0_fb = q[0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        em = 2'b10;
        if (m_ph == 1)      em = 2'b00;
        else if (m_ph == 2) em = bus.pause ? 2'b10 : 2'b01;
        if (chk_en) begin
            chk("mode", {30'd0, bus.C1, bus.C0}, {30'd0, em});
            chk("busy", {31'd0, bus.busy}, {31'd0, m_ph != 0});
            chk("done", {31'd0, bus.done}, {31'd0, m_ph == 3});
            chk("qreg", {28'd0, q}, {28'd0, m_q});
            if (em == 2'b01)
                chk("si", {31'd0, bus.si}, {31'd0, (m_rot ? m_q[0] : bus.ser_in)});
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cnt++;
            if ({bus.C1, bus.C0} == 2'b01) shift_cnt++;
        end
        // advance the model to what holds after the coming rising edge
        if (m_ph == 1) m_q = d;
        if (m_ph == 2 && !bus.pause) begin
            m_q = {(m_rot ? m_q[0] : bus.ser_in), m_q[3:1]};
            m_left--;
        end
        if (reset) begin
            m_ph = 0;
        end else begin
            case (m_ph)
                0: if (bus.start) begin
                       m_left = int'(bus.nshift);
                       m_rot  = bus.rotate;
                       m_ph   = 1;
                   end
                1: m_ph = (m_left != 0) ? 2 : 3;
                2: if (m_left == 0) m_ph = 3;
                default: m_ph = 0;
            endcase
        end
    end

    task automatic run_seq(input logic [3:0] dv, input logic [2:0] n, input logic rot,
                           input logic ser, input int p_at, input int p_len, input int s_at,
                           input logic [3:0] exp_q, input int exp_busy, input string tag);
        bit fin;
        busy_cnt  = 0;
        done_cnt  = 0;
        shift_cnt = 0;
        d          = dv;
        bus.nshift = n;
        bus.rotate = rot;
        bus.ser_in = ser;
        bus.start  = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        fin = 1'b0;
        for (int c = 1; c <= 200 && !fin; c++) begin
            @(posedge clock); #1;
            bus.pause = (c >= p_at) && (c < p_at + p_len);
            bus.start = (c == s_at);
            if (done_cnt > 0 && !bus.busy) fin = 1'b1;
        end
        bus.pause = 1'b0;
        bus.start = 1'b0;
        chk({tag, "_finished"}, {31'd0, fin}, 32'd1);
        chk({tag, "_final_q"}, {28'd0, q}, {28'd0, exp_q});
        chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
        chk({tag, "_done_pulses"}, done_cnt, 32'd1);
        chk({tag, "_shift_edges"}, shift_cnt, {29'd0, n});
    endtask

    initial begin
        reset      = 1'b1;
        d          = 4'h0;
        bus.start  = 1'b0;
        bus.nshift = '0;
        bus.rotate = 1'b0;
        bus.ser_in = 1'b0;
        bus.pause  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        chk("reset_mode", {30'd0, bus.C1, bus.C0}, 32'd2);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        @(posedge clock); #1;

        run_seq(4'b1011, 3'd2, 1'b0, 1'b1, 0, 0, 0, 4'b1110, 4, "load_shift2");
        run_seq(4'b1011, 3'd4, 1'b1, 1'b0, 0, 0, 0, 4'b1011, 6, "rotate4");
        run_seq(4'b0110, 3'd0, 1'b0, 1'b0, 0, 0, 0, 4'b0110, 2, "nshift0");
        run_seq(4'b1000, 3'd3, 1'b0, 1'b0, 2, 3, 0, 4'b0001, 8, "pause3");
        run_seq(4'b1011, 3'd3, 1'b0, 1'b1, 0, 0, 2, 4'b1111, 5, "start_in_shift");
        run_seq(4'b1011, 3'd5, 1'b1, 1'b0, 0, 0, 0, 4'b1101, 7, "nshift5");

        // reset lands in the third shift cycle; pause keeps that cycle in Hold
        d          = 4'b1011;
        bus.nshift = 3'd4;
        bus.rotate = 1'b0;
        bus.ser_in = 1'b0;
        bus.start  = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset     = 1'b1;
        bus.pause = 1'b1;
        @(posedge clock); #1;
        reset     = 1'b0;
        bus.pause = 1'b0;
        chk("midreset_mode", {30'd0, bus.C1, bus.C0}, 32'd2);
        chk("midreset_busy", {31'd0, bus.busy}, 32'd0);
        chk("midreset_done", {31'd0, bus.done}, 32'd0);
        chk("midreset_q", {28'd0, q}, 32'h2);
        repeat (2) @(posedge clock);
        #1;

        // start held for 12 cycles: accepted every 4th cycle
        busy_cnt   = 0;
        done_cnt   = 0;
        d          = 4'b0110;
        bus.nshift = 3'd1;
        bus.rotate = 1'b0;
        bus.ser_in = 1'b0;
        bus.start  = 1'b1;
        repeat (12) @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        chk("held_start_done_pulses", done_cnt, 32'd3);
        chk("held_start_busy_cycles", busy_cnt, 32'd9);
        chk("held_start_q", {28'd0, q}, 32'h3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qreg_seq.md
Name: qreg_seq

Overview:
- Sequencer for the 4-bit load/shift/hold register (qreg).
- On a start request it drives the register's mode controls to:
  1. Parallel-load the word on D.
  2. Shift right a programmable number of times, taking serial input from an external line or by rotating Q0 back in.
  3. Hold the result and signal completion.
- Sits beside qreg and is its only driver of C1/C0/si; D3..D0 reach qreg directly from the datapath.

Parameters:
- WIDTH, 4, width of the sequenced register; legal shift counts are 0..WIDTH.
- CNT_W, 3, width of nshift and the internal shift counter; must satisfy 2**CNT_W > WIDTH.

Ports:
- clock  in  1  rising-edge clock, shared with qreg.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request one load+shift sequence; sampled only in IDLE.
- nshift  in  CNT_W  number of shifts after load; captured when start is accepted.
- rotate  in  1  1: si = q0_fb (rotate); 0: si = ser_in; captured when start is accepted.
- ser_in  in  1  external serial bit, used when rotate=0.
- q0_fb  in  1  feedback from qreg Q0, used when rotate=1.
- pause  in  1  freezes the sequence during SHIFT.
- C1  out  1  qreg mode bit 1.
- C0  out  1  qreg mode bit 0.
- si  out  1  qreg serial input.
- busy  out  1  high from acceptance through the DONE cycle.
- done  out  1  one-cycle pulse in the DONE state.

Behaviour:
- Mode encoding on {C1,C0}: Load=00, Shift=01, Hold=10. The value 11 is never driven.
- States: IDLE, LOAD, SHIFT, DONE. State, counter, captured nshift and rotate are all registered.
- Reset (synchronous, on the edge where reset=1):
  - state=IDLE, cnt=0, rot_q=0.
  - Outputs: {C1,C0}=10, busy=0, done=0.
  - Reset overrides everything, including mid-sequence. qreg contents are not touched, because Hold is driven.
- IDLE:
  - {C1,C0}=10, busy=0.
  - If start=1 at an edge: cnt<=nshift, rot_q<=rotate, next state LOAD.
- LOAD:
  - {C1,C0}=00 for exactly one cycle; qreg loads D at the closing edge.
  - Next state: SHIFT if cnt!=0, otherwise DONE.
- SHIFT:
  - pause=0: {C1,C0}=01 and cnt decrements each edge. When cnt==1 at the edge, next state is DONE.
  - pause=1: {C1,C0}=10, and cnt and state are frozen. Pause is combinational on C1/C0; there is no extra latency on resume.
  - Exactly nshift Shift edges reach qreg regardless of how many pause cycles occur.
- DONE:
  - {C1,C0}=10, done=1, busy=1 for one cycle; then IDLE.
  - A start asserted in DONE is ignored.
- si = rot_q ? q0_fb : ser_in, combinational. It is only meaningful while {C1,C0}=01.
- busy=1 in LOAD, SHIFT and DONE. A start asserted while busy is ignored; it is not queued.
- nshift > WIDTH: the sequence still performs nshift shifts. The value is legal but software-undesired, and no clamp is applied.
- Latency: start accepted at edge k gives LOAD during cycle k+1, shifts at edges k+2..k+1+nshift (plus pause cycles), and done during the following cycle.
- pause outside SHIFT has no effect.

Decomposition:
- Shared package qreg_pkg:
  - Mode constants MODE_LOAD=2'b00, MODE_SHIFT=2'b01, MODE_HOLD=2'b10 (same values qreg decodes).
  - State enum for IDLE/LOAD/SHIFT/DONE.
- No sub-module; the counter and FSM are a single always block plus output decode.
- Bench top instantiates qreg_seq driving qreg, with q0_fb tied to Q0.

Test Plan:
- Reset mid-SHIFT (nshift=4, assert reset after 2 shifts) -> next cycle IDLE, {C1,C0}=10, busy=0, done=0; qreg retains its 2-shift value.
- D=1011, nshift=2, rotate=0, ser_in=1 -> LOAD one cycle, two Shift cycles, Q=1110 after the sequence, done pulses once, busy high for 4 cycles.
- D=1011, nshift=4, rotate=1 -> intermediate Q 1101, 1110, 0111, final Q=1011, done pulse.
- D=0110, nshift=0 -> LOAD then DONE directly, Q=0110, busy high for 2 cycles, no 01 ever driven.
- D=1000, nshift=3, ser_in=0, pause high for 3 cycles after the first shift -> exactly 3 Shift edges, final Q=0001, busy spans 8 cycles.
- Start held high continuously -> back-to-back sequences, each separated by one IDLE cycle; a start pulse during SHIFT produces no extra sequence; {C1,C0}=11 never observed (assertion).
